// File: rtl/pwm_capture_pkg.sv
// Shared types and default parameters for the PWM capture block.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    MEAS  = 2'd2,
    STUCK = 2'd3
  } state_e;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned TIMEOUT_DEF     = 60000;
  localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/pwm_capture_edge_sync.sv
// Input synchronizer for the asynchronous PWM line plus rise/fall detection.
module pwm_edge_sync
  import pwm_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_d_q;

  if (SYNC_STAGES < 1) begin : g_stage_chk
    $error("pwm_edge_sync: SYNC_STAGES must be at least 1");
  end

  // Shift chain; the last stage is the metastability-safe level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q  <= '0;
      pwm_d_q <= 1'b0;
    end else begin
      sync_q[0] <= pwm_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      pwm_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d_q;
  assign fall  = ~pwm_s & pwm_d_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM input and flags a stuck input.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pwm_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (64'(TIMEOUT) >= ((64'(1) << CNT_W) - 64'(1))) begin : g_timeout_chk
    $error("pwm_capture: TIMEOUT must be below 2**CNT_W-1");
  end

  logic pwm_s, rise, fall;

  pwm_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pwm_in    (pwm_in),
    .pwm_s     (pwm_s),
    .rise      (rise),
    .fall      (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic [CNT_W-1:0] per_cap_q, per_cap_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] period_d, high_time_d;
  logic             meas_valid_d, stuck_d, stuck_level_d;

  // Next-state and output logic; a completed period is published one clock after its closing rise.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_cap_d      = hi_cap_q;
    per_cap_d     = per_cap_q;
    pend_d        = 1'b0;
    period_d      = period;
    high_time_d   = high_time;
    meas_valid_d  = 1'b0;
    stuck_d       = stuck;
    stuck_level_d = stuck_level;

    if (pend_q && meas_en) begin
      period_d     = per_cap_q;
      high_time_d  = hi_cap_q;
      meas_valid_d = 1'b1;
    end

    if (!meas_en) begin
      state_d       = IDLE;
      cnt_d         = '0;
      stuck_d       = 1'b0;
      stuck_level_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = MEAS;
            cnt_d   = CNT_ONE;
          end else if (cnt_q == CNT_TO) begin
            state_d       = STUCK;
            stuck_d       = 1'b1;
            stuck_level_d = pwm_s;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        MEAS: begin
          if (rise) begin
            cnt_d     = CNT_ONE;
            per_cap_d = cnt_q;
            pend_d    = 1'b1;
          end else begin
            if (fall) hi_cap_d = cnt_q;
            if (cnt_q == CNT_TO) begin
              state_d       = STUCK;
              stuck_d       = 1'b1;
              stuck_level_d = pwm_s;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        STUCK: begin
          stuck_level_d = pwm_s;
          if (rise) begin
            state_d = MEAS;
            cnt_d   = CNT_ONE;
            stuck_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      per_cap_q   <= '0;
      pend_q      <= 1'b0;
      period      <= '0;
      high_time   <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_cap_q    <= hi_cap_d;
      per_cap_q   <= per_cap_d;
      pend_q      <= pend_d;
      period      <= period_d;
      high_time   <= high_time_d;
      meas_valid  <= meas_valid_d;
      stuck       <= stuck_d;
      stuck_level <= stuck_level_d;
    end
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the counter and of the measurement outputs.
REQ-002 SHALL have parameter TIMEOUT, default 60000, the number of clock cycles without a rising edge that declares the input stuck.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, the depth of the input synchronizer.
REQ-004 SHALL have ports:
- sys_clk  in  1  clock, 50 MHz nominal.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- pwm_in  in  1  asynchronous PWM input.
- meas_en  in  1  measurement enable.
- period  out  CNT_W  cycles between consecutive rising edges.
- high_time  out  CNT_W  high cycles within that period.
- meas_valid  out  1  one-cycle strobe; period and high_time updated.
- stuck  out  1  input has shown no rising edge for TIMEOUT cycles.
- stuck_level  out  1  synchronized input level while stuck is high.

Function
REQ-005 SHALL synchronize pwm_in through SYNC_STAGES flops, giving pwm_s; rise = pwm_s & ~pwm_s_d; fall = ~pwm_s & pwm_s_d.
REQ-006 SHALL implement states IDLE, ARM, MEAS, STUCK.
REQ-007 IDLE: entered whenever meas_en=0, from any state, on the next clock; in IDLE, cnt=0, stuck=0, and period/high_time hold their last values.
REQ-008 IDLE->ARM when meas_en=1.
REQ-009 ARM->MEAS on rise, with cnt<=1; in ARM, cnt counts from 0 and ARM->STUCK when cnt reaches TIMEOUT.
REQ-010 MEAS counter behaviour:
- on rise: cnt<=1.
- otherwise: cnt<=cnt+1, saturating at 2^CNT_W-1.
- Consequence: at the rise/fall cycle, cnt equals the number of cycles since the previous rise.
REQ-011 MEAS on fall: latch hi_cap<=cnt.
REQ-012 MEAS on rise: on the next clock, period<=cnt, high_time<=hi_cap, and meas_valid pulses for exactly 1 cycle.
REQ-013 Ideal input, high for H cycles then low for L cycles, SHALL report period=H+L and high_time=H.
REQ-014 Latency: meas_valid SHALL assert in the cycle after clock edge n+SYNC_STAGES+1, where edge n is the first edge that samples pwm_in high.
REQ-015 MEAS->STUCK when cnt reaches TIMEOUT without a rise; on entry, stuck<=1, stuck_level<=pwm_s, and no meas_valid is issued.
REQ-016 STUCK: stuck_level tracks pwm_s each cycle.
REQ-017 STUCK->MEAS on rise, with cnt<=1 and stuck<=0; the first subsequent rise yields meas_valid.
REQ-018 A rise and meas_en=0 in the same cycle: IDLE wins, and no meas_valid is issued.
REQ-019 meas_valid SHALL never assert in IDLE, ARM or STUCK, nor for the first rise after ARM.
REQ-020 TIMEOUT SHALL be less than 2^CNT_W-1, so saturation is unreachable in MEAS; an elaboration check SHALL enforce this.

Reset
REQ-021 Assertion of sys_rst_n=0 SHALL act immediately and asynchronously, setting:
- state=IDLE, cnt=0, hi_cap=0
- period=0, high_time=0
- meas_valid=0, stuck=0, stuck_level=0
- all synchronizer flops=0
REQ-022 Reset asserted mid-measurement SHALL discard the partial measurement.
REQ-023 After release with meas_en=1, the first meas_valid SHALL require two rises.

Structure
REQ-024 The shared package pwm_capture_pkg SHALL hold:
- the state enum (IDLE, ARM, MEAS, STUCK)
- default CNT_W=16
- default TIMEOUT=60000
- default SYNC_STAGES=2
REQ-025 The synchronizer and edge detector SHALL be one sub-module, pwm_edge_sync, with outputs pwm_s, rise and fall.
REQ-026 The state machine and counters SHALL reside in pwm_capture.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Steady PWM, H=30000, L=20000, meas_en=1 -> first meas_valid at the second rise; every later strobe reports period=50000, high_time=30000.
- Duty sweep, H stepping 25 cycles per period, period 50000 -> each strobe reports high_time = previous+25, period=50000, strobes exactly 50000 cycles apart.
- pwm_in held low 70000 cycles after lock -> stuck=1 at cnt=60000, stuck_level=0, no meas_valid; then resume H=100/L=100 -> stuck=0 at first rise, next strobe period=200, high_time=100.
- pwm_in held high -> stuck=1, stuck_level=1; then a 1-cycle low glitch -> on the following rise, state returns to MEAS and no strobe is issued for the partial period.
- meas_en dropped mid-period with H=L=500 -> no strobe, outputs hold; re-enable -> strobe only at the second rise.
- sys_rst_n pulsed low asynchronously mid-high-phase -> all outputs 0 immediately; post-release behaviour matches a cold start.
